// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and the parity helper
// used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } state_t;

  localparam int PAR_NONE      = 0;
  localparam int PAR_EVEN      = 1;
  localparam int PAR_ODD       = 2;
  localparam int MAX_DATA_BITS = 9;

  // Returns the parity bit a transmitter would send for this data; unused bits must be 0.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input int mode);
    if (mode == PAR_ODD)
      return ~(^data);
    else if (mode == PAR_EVEN)
      return ^data;
    else
      return 1'b0;
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Clock divider producing a one-clk oversample tick, plus the oversample counter
// that advances on each tick; clear restarts both so ticks align to an edge.
module uart_tick_gen #(
  parameter int CLK_DIV    = 4,
  parameter int OVERSAMPLE = 16,
  parameter int OS_W       = $clog2(OVERSAMPLE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  output logic            tick,
  output logic [OS_W-1:0] os_cnt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      os_cnt  <= '0;
    end else if (clear) begin
      div_cnt <= '0;
      os_cnt  <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      os_cnt  <= (os_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with configurable data/parity/stop format, start-bit
// validation, error flags and an output register held until read.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int CLK_DIV    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 rx,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_rdy,
  output logic                 d_rdy,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 overrun_err
);

  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam int OS_W  = $clog2(OVERSAMPLE);

  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS || PARITY < PAR_NONE || PARITY > PAR_ODD ||
      STOP_BITS < 1 || STOP_BITS > 2 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
      CLK_DIV < 1) begin : g_param_check
    $error("uart_rx_os: illegal parameter combination");
  end

  logic [1:0]               sync_q;
  logic                     rxs;
  state_t                   state, state_nxt;
  logic                     tick, sample, cnt_clr;
  logic [OS_W-1:0]          os_cnt;
  logic [BIT_W-1:0]         bit_idx;
  logic                     stop_idx;
  logic [DATA_BITS-1:0]     shreg;
  logic [MAX_DATA_BITS-1:0] par_data;
  logic                     perr, ferr;

  // Resets to 1 so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], rx};
  end

  assign rxs = sync_q[1];

  uart_tick_gen #(
    .CLK_DIV    (CLK_DIV),
    .OVERSAMPLE (OVERSAMPLE),
    .OS_W       (OS_W)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clr),
    .tick   (tick),
    .os_cnt (os_cnt)
  );

  // START samples half a bit in; clearing there puts every later sample mid-bit.
  always_comb begin
    sample = 1'b0;
    if (state == ST_START)
      sample = tick && (os_cnt == OS_W'(OVERSAMPLE / 2 - 1));
    else
      sample = tick && (os_cnt == OS_W'(OVERSAMPLE - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (en && !rxs) state_nxt = ST_START;
      end
      ST_START: begin
        if (sample) begin
          cnt_clr   = 1'b1;
          state_nxt = rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (sample && bit_idx == BIT_W'(DATA_BITS - 1))
          state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (sample) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (sample && stop_idx == 1'(STOP_BITS - 1)) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    par_data                = '0;
    par_data[DATA_BITS-1:0] = shreg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_START: begin
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          perr     <= 1'b0;
          ferr     <= 1'b0;
        end
        ST_DATA: begin
          if (sample) begin
            shreg   <= {rxs, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
          end
        end
        ST_PARITY: begin
          if (sample) perr <= (calc_parity(par_data, PARITY) != rxs);
        end
        ST_STOP: begin
          if (sample) begin
            ferr     <= ferr | ~rxs;
            stop_idx <= stop_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A completed frame always wins over a read in the same clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout        <= '0;
      d_rdy       <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else if (state == ST_DONE) begin
      dout        <= shreg;
      parity_err  <= perr;
      framing_err <= ferr;
      overrun_err <= overrun_err | d_rdy;
      d_rdy       <= 1'b1;
    end else if (rd && d_rdy) begin
      d_rdy       <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

  assign rx_rdy = (state == ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: three instances cover 8N1, 7O1 and 8N2
// formats; a queue of expected frames is filled as frames are driven.
module tb_uart_rx_os;

  localparam int CLK_DIV = 4;
  localparam int OS      = 16;
  localparam int BIT_CLK = CLK_DIV * OS;
  // two sync flops + IDLE->START, half a bit to the start sample, 9 bit periods, DONE
  localparam int LAT_8N1 = 3 + BIT_CLK / 2 + BIT_CLK * 9 + 1;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en_a = 1'b1, en_p = 1'b1, en_s = 1'b1;
  logic rx_a = 1'b1, rx_p = 1'b1, rx_s = 1'b1;
  logic rd_a = 1'b0, rd_p = 1'b0, rd_s = 1'b0;

  logic [7:0] dout_a, dout_s;
  logic [6:0] dout_p;
  logic rx_rdy_a, d_rdy_a, perr_a, ferr_a, ovr_a;
  logic rx_rdy_p, d_rdy_p, perr_p, ferr_p, ovr_p;
  logic rx_rdy_s, d_rdy_s, perr_s, ferr_s, ovr_s;

  exp_t sb_q[$];
  logic pend [3] = '{1'b0, 1'b0, 1'b0};
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  uart_rx_os #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OS), .CLK_DIV(CLK_DIV)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .rx(rx_a), .rd(rd_a), .dout(dout_a), .rx_rdy(rx_rdy_a),
    .d_rdy(d_rdy_a), .parity_err(perr_a), .framing_err(ferr_a), .overrun_err(ovr_a));

  uart_rx_os #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(OS), .CLK_DIV(CLK_DIV)) dut_p (
    .clk(clk), .rst(rst), .en(en_p), .rx(rx_p), .rd(rd_p), .dout(dout_p), .rx_rdy(rx_rdy_p),
    .d_rdy(d_rdy_p), .parity_err(perr_p), .framing_err(ferr_p), .overrun_err(ovr_p));

  uart_rx_os #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(OS), .CLK_DIV(CLK_DIV)) dut_s (
    .clk(clk), .rst(rst), .en(en_s), .rx(rx_s), .rd(rd_s), .dout(dout_s), .rx_rdy(rx_rdy_s),
    .d_rdy(d_rdy_s), .parity_err(perr_s), .framing_err(ferr_s), .overrun_err(ovr_s));

  task automatic drive_rx(input int which, input logic v);
    case (which)
      0:       rx_a = v;
      1:       rx_p = v;
      default: rx_s = v;
    endcase
  endtask

  // Drives one frame starting on the next negedge; pushes the model's expectation.
  task automatic apply_frame(input int which, input logic [8:0] data, input int nbits,
                             input bit use_par, input logic pbit, input bit odd,
                             input int nstop, input logic [1:0] stops, input bit expect_rx);
    exp_t       e;
    logic [8:0] masked;
    masked = data & ((9'h1 << nbits) - 9'h1);
    @(negedge clk);
    drive_rx(which, 1'b0);
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      drive_rx(which, masked[i]);
      repeat (BIT_CLK) @(negedge clk);
    end
    if (use_par) begin
      drive_rx(which, pbit);
      repeat (BIT_CLK) @(negedge clk);
    end
    for (int s = 0; s < nstop; s++) begin
      drive_rx(which, stops[s]);
      repeat (BIT_CLK) @(negedge clk);
    end
    drive_rx(which, 1'b1);
    if (expect_rx) begin
      e.data = masked;
      e.perr = use_par && (((^masked) ^ pbit) != odd);
      e.ferr = 1'b0;
      for (int s = 0; s < nstop; s++) if (!stops[s]) e.ferr = 1'b1;
      e.ovr  = pend[which];
      pend[which] = 1'b1;
      sb_q.push_back(e);
    end
  endtask

  task automatic read_pulse(input int which);
    @(negedge clk);
    case (which)
      0:       rd_a = 1'b1;
      1:       rd_p = 1'b1;
      default: rd_s = 1'b1;
    endcase
    @(negedge clk);
    rd_a = 1'b0; rd_p = 1'b0; rd_s = 1'b0;
    pend[which] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++; if (dout_a !== 8'h00) begin n_err++; $display("[TB] FAIL reset_dout: got %0h want 0", dout_a); end
    n_vec++; if (rx_rdy_a !== 1'b1) begin n_err++; $display("[TB] FAIL reset_rx_rdy: got %b want 1", rx_rdy_a); end
    n_vec++; if (d_rdy_a !== 1'b0) begin n_err++; $display("[TB] FAIL reset_d_rdy: got %b want 0", d_rdy_a); end
    n_vec++; if ({perr_a, ferr_a, ovr_a} !== 3'b000) begin n_err++; $display("[TB] FAIL reset_flags: got %b want 000", {perr_a, ferr_a, ovr_a}); end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    exp_t e;
    int   lat;
    lat = -1;
    fork
      apply_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1, 2'b11, 1'b1);
      begin
        @(negedge clk);
        for (int i = 1; i <= 2000; i++) begin
          @(posedge clk); #1;
          if (d_rdy_a) begin lat = i; break; end
        end
      end
    join
    e = sb_q.pop_front();
    n_vec++; if (lat != LAT_8N1) begin n_err++; $display("[TB] FAIL basic_latency: got %0d want %0d", lat, LAT_8N1); end
    n_vec++; if (dout_a !== e.data[7:0]) begin n_err++; $display("[TB] FAIL basic_dout: got %0h want %0h", dout_a, e.data[7:0]); end
    n_vec++; if (d_rdy_a !== 1'b1) begin n_err++; $display("[TB] FAIL basic_d_rdy: got %b want 1", d_rdy_a); end
    n_vec++; if ({perr_a, ferr_a, ovr_a} !== {e.perr, e.ferr, e.ovr}) begin n_err++; $display("[TB] FAIL basic_flags: got %b want %b", {perr_a, ferr_a, ovr_a}, {e.perr, e.ferr, e.ovr}); end
    n_vec++; if (rx_rdy_a !== 1'b1) begin n_err++; $display("[TB] FAIL basic_rx_rdy: got %b want 1", rx_rdy_a); end
    read_pulse(0);
    n_vec++; if (d_rdy_a !== 1'b0) begin n_err++; $display("[TB] FAIL basic_rd_clear: got %b want 0", d_rdy_a); end
    n_vec++; if (dout_a !== 8'hA5) begin n_err++; $display("[TB] FAIL basic_dout_hold: got %0h want a5", dout_a); end
  endtask

  task automatic test_false_start();
    exp_t e;
    @(negedge clk);
    rx_a = 1'b0;
    repeat (10) @(negedge clk);
    n_vec++; if (rx_rdy_a !== 1'b0) begin n_err++; $display("[TB] FAIL fstart_in_start: got %b want 0", rx_rdy_a); end
    repeat (10) @(negedge clk);
    rx_a = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    n_vec++; if (d_rdy_a !== 1'b0) begin n_err++; $display("[TB] FAIL fstart_d_rdy: got %b want 0", d_rdy_a); end
    n_vec++; if (rx_rdy_a !== 1'b1) begin n_err++; $display("[TB] FAIL fstart_idle: got %b want 1", rx_rdy_a); end
    apply_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 1, 2'b11, 1'b1);
    e = sb_q.pop_front();
    n_vec++; if (dout_a !== e.data[7:0]) begin n_err++; $display("[TB] FAIL fstart_dout: got %0h want %0h", dout_a, e.data[7:0]); end
    n_vec++; if ({d_rdy_a, ferr_a, ovr_a} !== {1'b1, e.ferr, e.ovr}) begin n_err++; $display("[TB] FAIL fstart_status: got %b want %b", {d_rdy_a, ferr_a, ovr_a}, {1'b1, e.ferr, e.ovr}); end
    read_pulse(0);
  endtask

  task automatic test_parity();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      apply_frame(1, 9'h055, 7, 1'b1, logic'(k), 1'b1, 1, 2'b11, 1'b1);
      e = sb_q.pop_front();
      n_vec++; if (dout_p !== e.data[6:0]) begin n_err++; $display("[TB] FAIL parity_dout%0d: got %0h want %0h", k, dout_p, e.data[6:0]); end
      n_vec++; if (perr_p !== e.perr) begin n_err++; $display("[TB] FAIL parity_err%0d: got %b want %b", k, perr_p, e.perr); end
      n_vec++; if ({d_rdy_p, ferr_p} !== {1'b1, e.ferr}) begin n_err++; $display("[TB] FAIL parity_status%0d: got %b want %b", k, {d_rdy_p, ferr_p}, {1'b1, e.ferr}); end
      read_pulse(1);
    end
  endtask

  task automatic test_stop_bits();
    exp_t e;
    fork
      apply_frame(2, 9'h081, 8, 1'b0, 1'b0, 1'b0, 2, 2'b01, 1'b1);
      begin
        repeat (BIT_CLK * 10 + 8) @(negedge clk);
        en_s = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    en_s = 1'b1;
    e = sb_q.pop_front();
    n_vec++; if (dout_s !== e.data[7:0]) begin n_err++; $display("[TB] FAIL stop_dout: got %0h want %0h", dout_s, e.data[7:0]); end
    n_vec++; if (ferr_s !== e.ferr) begin n_err++; $display("[TB] FAIL stop_ferr: got %b want %b", ferr_s, e.ferr); end
    n_vec++; if ({d_rdy_s, perr_s} !== {1'b1, e.perr}) begin n_err++; $display("[TB] FAIL stop_status: got %b want %b", {d_rdy_s, perr_s}, {1'b1, e.perr}); end
    read_pulse(2);
  endtask

  task automatic test_overrun();
    exp_t e;
    apply_frame(0, 9'h011, 8, 1'b0, 1'b0, 1'b0, 1, 2'b11, 1'b1);
    e = sb_q.pop_front();
    n_vec++; if ({d_rdy_a, ovr_a} !== {1'b1, e.ovr}) begin n_err++; $display("[TB] FAIL ovr_first: got %b want %b", {d_rdy_a, ovr_a}, {1'b1, e.ovr}); end
    apply_frame(0, 9'h022, 8, 1'b0, 1'b0, 1'b0, 1, 2'b11, 1'b1);
    e = sb_q.pop_front();
    n_vec++; if (dout_a !== e.data[7:0]) begin n_err++; $display("[TB] FAIL ovr_dout: got %0h want %0h", dout_a, e.data[7:0]); end
    n_vec++; if (ovr_a !== e.ovr) begin n_err++; $display("[TB] FAIL ovr_flag: got %b want %b", ovr_a, e.ovr); end
    read_pulse(0);
    n_vec++; if ({d_rdy_a, ovr_a} !== 2'b00) begin n_err++; $display("[TB] FAIL ovr_rd_clear: got %b want 00", {d_rdy_a, ovr_a}); end
    n_vec++; if (dout_a !== 8'h22) begin n_err++; $display("[TB] FAIL ovr_dout_hold: got %0h want 22", dout_a); end
  endtask

  task automatic test_reset_enable();
    exp_t e;
    apply_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1'b0, 1, 2'b11, 1'b1);
    e = sb_q.pop_front();
    n_vec++; if (dout_a !== e.data[7:0]) begin n_err++; $display("[TB] FAIL rst_pre_dout: got %0h want %0h", dout_a, e.data[7:0]); end
    @(negedge clk);
    rx_a = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    rx_a = 1'b1;
    repeat (BIT_CLK * 4 + BIT_CLK / 2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_vec++; if (dout_a !== 8'h00) begin n_err++; $display("[TB] FAIL rst_mid_dout: got %0h want 0", dout_a); end
    n_vec++; if ({rx_rdy_a, d_rdy_a} !== 2'b10) begin n_err++; $display("[TB] FAIL rst_mid_rdy: got %b want 10", {rx_rdy_a, d_rdy_a}); end
    n_vec++; if ({perr_a, ferr_a, ovr_a} !== 3'b000) begin n_err++; $display("[TB] FAIL rst_mid_flags: got %b want 000", {perr_a, ferr_a, ovr_a}); end
    pend = '{1'b0, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    apply_frame(0, 9'h00F, 8, 1'b0, 1'b0, 1'b0, 1, 2'b11, 1'b1);
    e = sb_q.pop_front();
    n_vec++; if (dout_a !== e.data[7:0]) begin n_err++; $display("[TB] FAIL rst_after_dout: got %0h want %0h", dout_a, e.data[7:0]); end
    n_vec++; if ({d_rdy_a, ovr_a} !== {1'b1, e.ovr}) begin n_err++; $display("[TB] FAIL rst_after_status: got %b want %b", {d_rdy_a, ovr_a}, {1'b1, e.ovr}); end
    read_pulse(0);
    en_a = 1'b0;
    apply_frame(0, 9'h0C3, 8, 1'b0, 1'b0, 1'b0, 1, 2'b11, 1'b0);
    n_vec++; if (d_rdy_a !== 1'b0) begin n_err++; $display("[TB] FAIL en_off_d_rdy: got %b want 0", d_rdy_a); end
    n_vec++; if (dout_a !== 8'h0F) begin n_err++; $display("[TB] FAIL en_off_dout: got %0h want 0f", dout_a); end
    n_vec++; if (rx_rdy_a !== 1'b1) begin n_err++; $display("[TB] FAIL en_off_idle: got %b want 1", rx_rdy_a); end
    en_a = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_parity();
    test_stop_bits();
    test_overrun();
    test_reset_enable();
    n_vec++; if (sb_q.size() != 0) begin n_err++; $display("[TB] FAIL scoreboard_drain: got %0d want 0", sb_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Parametrised, oversampling UART receiver. Successor to the single-shot 8-bit receiver.
- Adds configurable frame format: data bits, parity and stop bits.
- Adds an on-chip baud/oversample tick, start-bit validation, error flags and a hold-until-read output register.
- Sits between the pad-side rx line and the controller's register/FIFO layer.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, stop bits checked; 1 or 2.
- OVERSAMPLE, 16, oversample ticks per bit period; even, at least 8.
- CLK_DIV, 4, clk cycles per oversample tick; at least 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  receive enable; sampled only in IDLE.
- rx  in  1  serial input, asynchronous to clk.
- rd  in  1  read strobe; consumes the held frame.
- dout  out  DATA_BITS  received data, first received bit at dout[0].
- rx_rdy  out  1  high while in IDLE, i.e. ready to accept a start bit.
- d_rdy  out  1  high while dout holds an unread frame.
- parity_err  out  1  parity mismatch on the held frame.
- framing_err  out  1  a stop bit sampled 0 on the held frame.
- overrun_err  out  1  a frame completed while d_rdy was already high; sticky until rd.

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous release):
  - dout=0, rx_rdy=1, d_rdy=0, all error flags 0.
  - FSM goes to IDLE; all counters are cleared.
  - The synchroniser resets to 1 (line idle).
  - A reset mid-frame discards the partial frame.
- Synchroniser: rx passes through 2 flops. All decisions use the synchronised value rxs.
- Tick generator: a counter 0..CLK_DIV-1 emits a 1-clk tick on wrap. The counter is held at 0 in IDLE, so ticks are phase-aligned to the start edge.
- Oversample counter: counts 0..OVERSAMPLE-1 on ticks. The mid-bit sample point is count OVERSAMPLE/2-1 in START, and count OVERSAMPLE-1 in every later state.
- IDLE:
  - rx_rdy=1.
  - If en=1 and rxs=0, go to START and clear the counters.
  - en=0 ignores the line. en changes outside IDLE have no effect.
- START: at the mid sample:
  - rxs=1 is a false start: go back to IDLE, with no output and no flags.
  - rxs=0 goes to DATA with the bit index cleared.
- DATA:
  - At each mid sample, shift rxs into the shift register LSB-first and increment the bit index.
  - After DATA_BITS samples, go to PARITY if PARITY!=0, else to STOP.
- PARITY:
  - Sample once.
  - perr = (XOR of the data bits XOR the sample), inverted for odd parity.
- STOP:
  - Sample STOP_BITS times.
  - ferr = any stop sample equal to 0.
  - After the last stop sample, go to DONE.
- DONE (one clk):
  - Load dout, parity_err and framing_err.
  - overrun_err is set if d_rdy was 1; the new frame overwrites the old one.
  - Set d_rdy=1, return to IDLE.
  - Latency: d_rdy rises one clk after the clk on which the last stop sample is taken.
- rd:
  - rd=1 with d_rdy=1 clears d_rdy and overrun_err on the next clk.
  - dout, parity_err and framing_err keep their values.
  - rd with d_rdy=0 is ignored.
- rd in the same clk as DONE: the load wins. d_rdy stays 1, and overrun_err is set if d_rdy was 1 in that clk.
- Framing error: the frame is still delivered. Re-arm is not gated on the line returning high; IDLE requires rxs=0 anyway, so a line stuck low produces repeated framing-error frames.
- Widths:
  - Bit index: $clog2(DATA_BITS+1).
  - Oversample counter: $clog2(OVERSAMPLE).
  - Divider: $clog2(CLK_DIV) with a minimum of 1 bit.
- Illegal parameters (DATA_BITS outside 5..9, PARITY>2, STOP_BITS outside 1..2, odd OVERSAMPLE) are rejected by an elaboration-time check.

Decomposition:
- Shared package uart_pkg:
  - State encoding IDLE, START, DATA, PARITY, STOP, DONE.
  - Parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD.
  - A shared calc_parity function, also used by the transmitter.
- One natural sub-module: uart_tick_gen, containing the divider plus the oversample counter with a clear input. It is reused by the transmitter.

Test Plan:
- Basic frame: CLK_DIV=4, OVERSAMPLE=16 (64 clk per bit), 8N1, send 0xA5 LSB-first -> dout=0xA5, d_rdy=1, all errors 0, rx_rdy=1; then rd pulse -> d_rdy=0 on the next clk, dout stays 0xA5.
- False start: rx low for 20 clk, then high -> no d_rdy, FSM back in IDLE, rx_rdy=1; a following 0x3C frame is received correctly.
- Parity: PARITY=2 (odd), DATA_BITS=7, send 0x55 with parity bit 0 -> dout=0x55, parity_err=1; resend with parity bit 1 -> parity_err=0.
- Stop bits: STOP_BITS=2, send 0x81 with the second stop bit 0 -> framing_err=1, dout=0x81, d_rdy=1.
- Overrun: send 0x11 then 0x22 with no rd -> dout=0x22, overrun_err=1; rd -> overrun_err=0, d_rdy=0.
- Reset and enable: assert rst after 4 data bits of 0xFF -> all outputs return to reset values immediately; after release, 0x0F is received correctly; with en=0, a full frame is ignored.
